// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 block: register numbers, exception codes,
// Status/Cause bit positions and reset values.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;

  localparam int CAUSE_BD = 31;

  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
  // IM[15:8], EXL[1], IE[0]; everything else keeps its reset value.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CONFIG_VALUE = 32'h0000_8000;

  // Address-error exceptions are the only ones that latch BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with prescaler and sticky compare-match interrupt.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             tint_q, tint_d;
  logic             tick;

  // Prescaler tick, Count/Compare next state and sticky match flag.
  always_comb begin
    tick      = (div_q == DIV_W'(COUNT_DIV - 1));
    div_d     = tick ? '0 : div_q + 1'b1;
    count_d   = count_q;
    compare_d = compare_q;
    tint_d    = tint_q;
    if (count_we_i)
      count_d = wdata_i;
    else if (tick)
      count_d = count_q + 32'd1;
    // A Compare write acknowledges the interrupt and wins over a fresh match.
    if (compare_we_i) begin
      compare_d = wdata_i;
      tint_d    = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      tint_d = 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      tint_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      tint_q    <= tint_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_unit.sv
// MIPS coprocessor 0: architected registers, interrupt merge, exception/ERET
// commit with EXL nesting and a registered fetch redirect.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 5,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VALUE = 32'h004C_0102,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           rdata_o,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic                  eret_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  in_delayslot_i,
  input  logic [31:0]           badvaddr_i,
  output logic                  int_pending_o,
  output logic                  redirect_valid_o,
  output logic [31:0]           redirect_pc_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  ip_hw_q;
  logic        ip7_q;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [4:0]  hw_pad;
  logic        wr_ok;
  logic [31:0] count, compare;
  logic        timer_int;
  logic [31:0] cause;

  // Lines beyond NUM_HW_INT read back as zero in Cause.IP.
  assign hw_pad = 5'(hw_int_i);

  // An exception or ERET in the same cycle swallows any MTC0.
  assign wr_ok = we_i & ~exc_valid_i & ~eret_i;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (wr_ok && (waddr_i == REG_COUNT)),
    .compare_we_i (wr_ok && (waddr_i == REG_COMPARE)),
    .wdata_i      (wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .timer_int_o  (timer_int)
  );

  // Next-state for Status/Cause/EPC/BadVAddr and the redirect, by priority.
  always_comb begin
    status_d      = status_q;
    epc_d         = epc_q;
    badvaddr_d    = badvaddr_q;
    bd_d          = bd_q;
    code_d        = code_q;
    ip_sw_d       = ip_sw_q;
    redir_valid_d = exc_valid_i | eret_i;
    redir_pc_d    = redir_pc_q;
    if (exc_valid_i) begin
      // A nested exception keeps the original return point.
      if (!status_q[STATUS_EXL]) begin
        epc_d = in_delayslot_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        bd_d  = in_delayslot_i;
      end
      status_d[STATUS_EXL] = 1'b1;
      code_d               = exc_code_i;
      if (is_addr_exc(exc_code_i))
        badvaddr_d = badvaddr_i;
      redir_pc_d = EXC_VECTOR;
    end else if (eret_i) begin
      status_d[STATUS_EXL] = 1'b0;
      redir_pc_d           = epc_q;
    end else if (we_i) begin
      case (waddr_i)
        REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
        REG_CAUSE:  ip_sw_d  = wdata_i[9:8];
        REG_EPC:    epc_d    = wdata_i;
        default:    ;
      endcase
    end
  end

  // Architected register state and redirect pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q      <= STATUS_RESET;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      bd_q          <= 1'b0;
      code_q        <= '0;
      ip_sw_q       <= '0;
      ip_hw_q       <= '0;
      ip7_q         <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      status_q      <= status_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      bd_q          <= bd_d;
      code_q        <= code_d;
      ip_sw_q       <= ip_sw_d;
      ip_hw_q       <= hw_pad;
      ip7_q         <= timer_int;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign cause = {bd_q, 15'd0, ip7_q, ip_hw_q, ip_sw_q, 1'b0, code_q, 2'b00};

  // MFC0 read mux.
  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr_q;
      REG_COUNT:    rdata_o = count;
      REG_COMPARE:  rdata_o = compare;
      REG_STATUS:   rdata_o = status_q;
      REG_CAUSE:    rdata_o = cause;
      REG_EPC:      rdata_o = epc_q;
      REG_PRID:     rdata_o = PRID_VALUE;
      REG_CONFIG:   rdata_o = CONFIG_VALUE;
      default:      rdata_o = 32'd0;
    endcase
  end

  assign int_pending_o    = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                            (|(cause[15:8] & status_q[15:8]));
  assign redirect_valid_o = redir_valid_q;
  assign redirect_pc_o    = redir_pc_q;
  assign status_o         = status_q;
  assign cause_o          = cause;
  assign epc_o            = epc_q;
  assign timer_int_o      = timer_int;

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [4:0]  hw_int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic        eret_i;
  logic [31:0] exc_pc_i;
  logic        in_delayslot_i;
  logic [31:0] badvaddr_i;
  logic        int_pending_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model_epc;
  logic [31:0] exp_pc;

  cp0_unit dut (
    .clk              (clk),
    .rst              (rst),
    .we_i             (we_i),
    .waddr_i          (waddr_i),
    .wdata_i          (wdata_i),
    .raddr_i          (raddr_i),
    .rdata_o          (rdata_o),
    .hw_int_i         (hw_int_i),
    .exc_valid_i      (exc_valid_i),
    .exc_code_i       (exc_code_i),
    .eret_i           (eret_i),
    .exc_pc_i         (exc_pc_i),
    .in_delayslot_i   (in_delayslot_i),
    .badvaddr_i       (badvaddr_i),
    .int_pending_o    (int_pending_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .status_o         (status_o),
    .cause_o          (cause_o),
    .epc_o            (epc_o),
    .timer_int_o      (timer_int_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc,
                           input logic ds, input logic [31:0] bva);
    exc_valid_i = 1'b1; exc_code_i = code; exc_pc_i = pc;
    in_delayslot_i = ds; badvaddr_i = bva;
    sb_q.push_back(32'hBFC0_0380);
    tick();
    exc_valid_i = 1'b0; in_delayslot_i = 1'b0;
  endtask

  task automatic raise_eret();
    eret_i = 1'b1;
    sb_q.push_back(model_epc);
    tick();
    eret_i = 1'b0;
  endtask

  // Waits (bounded) for the redirect pulse, pops the scoreboard and checks
  // the pulse lasts exactly one cycle.
  task automatic check_redirect(input string tag);
    int n = 0;
    while (redirect_valid_o !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    total_cnt++;
    if (redirect_valid_o !== 1'b1) begin
      $display("FAIL %s_redirect_timeout: no redirect_valid_o within 8 cycles", tag);
    end else if (sb_q.size() == 0) begin
      $display("FAIL %s_redirect_unexpected: pc=%h with empty scoreboard", tag, redirect_pc_o);
    end else begin
      exp_pc = sb_q.pop_front();
      if (redirect_pc_o !== exp_pc)
        $display("FAIL %s_redirect_pc: got %h expected %h", tag, redirect_pc_o, exp_pc);
      else
        pass_cnt++;
    end
    tick();
    total_cnt++;
    if (redirect_valid_o !== 1'b0)
      $display("FAIL %s_redirect_width: valid got %b expected 0", tag, redirect_valid_o);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    logic [4:0]  addrs[9];
    logic [31:0] exps[9];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    exps  = '{32'h0, 32'h0, 32'h0, 32'h1000_0000, 32'h0, 32'h0,
              32'h004C_0102, 32'h0000_8000, 32'h0};
    for (int i = 0; i < 9; i++) begin
      raddr_i = addrs[i];
      #1;
      total_cnt++;
      if (rdata_o !== exps[i])
        $display("FAIL reset_read_%0d: got %h expected %h", addrs[i], rdata_o, exps[i]);
      else
        pass_cnt++;
    end
    total_cnt++;
    if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'h0)
      $display("FAIL reset_redirect: valid %b pc %h expected 0/0", redirect_valid_o, redirect_pc_o);
    else
      pass_cnt++;
    total_cnt++;
    if (timer_int_o !== 1'b0 || int_pending_o !== 1'b0)
      $display("FAIL reset_irq: timer %b pending %b expected 0/0", timer_int_o, int_pending_o);
    else
      pass_cnt++;
  endtask

  task automatic test_timer();
    int n = 0;
    mtc0(5'd11, 32'd10);
    raddr_i = 5'd9;
    #1;
    while (rdata_o !== 32'd10 && n < 200) begin
      tick();
      n++;
    end
    total_cnt++;
    if (rdata_o !== 32'd10 || timer_int_o !== 1'b0)
      $display("FAIL timer_reach: count %0d timer %b expected 10/0", rdata_o, timer_int_o);
    else
      pass_cnt++;
    tick();
    total_cnt++;
    if (timer_int_o !== 1'b1)
      $display("FAIL timer_rise: got %b expected 1", timer_int_o);
    else
      pass_cnt++;
    mtc0(5'd12, 32'h0000_8001);
    total_cnt++;
    if (int_pending_o !== 1'b1 || status_o !== 32'h1000_8001)
      $display("FAIL timer_pending: pending %b status %h expected 1/10008001",
               int_pending_o, status_o);
    else
      pass_cnt++;
    mtc0(5'd11, 32'd20);
    total_cnt++;
    if (timer_int_o !== 1'b0)
      $display("FAIL timer_clear: got %b expected 0", timer_int_o);
    else
      pass_cnt++;
    mtc0(5'd12, 32'h0);
    mtc0(5'd11, 32'h0);
  endtask

  task automatic test_exception();
    raise_exc(5'd4, 32'h8000_0104, 1'b1, 32'h1234_5679);
    model_epc = 32'h8000_0100;
    total_cnt++;
    if (epc_o !== model_epc)
      $display("FAIL exc_epc: got %h expected %h", epc_o, model_epc);
    else
      pass_cnt++;
    total_cnt++;
    if (cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd4)
      $display("FAIL exc_cause: bd %b code %0d expected 1/4", cause_o[31], cause_o[6:2]);
    else
      pass_cnt++;
    total_cnt++;
    if (status_o[1] !== 1'b1)
      $display("FAIL exc_exl: got %b expected 1", status_o[1]);
    else
      pass_cnt++;
    raddr_i = 5'd8;
    #1;
    total_cnt++;
    if (rdata_o !== 32'h1234_5679)
      $display("FAIL exc_badvaddr: got %h expected 12345679", rdata_o);
    else
      pass_cnt++;
    check_redirect("exc");
  endtask

  task automatic test_nested_eret();
    raise_exc(5'd8, 32'h8000_0200, 1'b0, 32'hDEAD_BEEF);
    total_cnt++;
    if (epc_o !== model_epc || cause_o[31] !== 1'b1)
      $display("FAIL nested_epc: epc %h bd %b expected %h/1", epc_o, cause_o[31], model_epc);
    else
      pass_cnt++;
    total_cnt++;
    if (cause_o[6:2] !== 5'd8)
      $display("FAIL nested_code: got %0d expected 8", cause_o[6:2]);
    else
      pass_cnt++;
    raddr_i = 5'd8;
    #1;
    total_cnt++;
    if (rdata_o !== 32'h1234_5679)
      $display("FAIL nested_badvaddr: got %h expected 12345679", rdata_o);
    else
      pass_cnt++;
    check_redirect("nested");
    raise_eret();
    total_cnt++;
    if (status_o[1] !== 1'b0)
      $display("FAIL eret_exl: got %b expected 0", status_o[1]);
    else
      pass_cnt++;
    check_redirect("eret");
  endtask

  task automatic test_back_to_back_priority();
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0000_FF01;
    raise_exc(5'd0, 32'h8000_0300, 1'b0, 32'h0);
    we_i = 1'b0;
    model_epc = 32'h8000_0300;
    total_cnt++;
    if (status_o !== 32'h1000_0002)
      $display("FAIL prio_status: got %h expected 10000002", status_o);
    else
      pass_cnt++;
    total_cnt++;
    if (epc_o !== model_epc || cause_o[31] !== 1'b0)
      $display("FAIL prio_epc: epc %h bd %b expected %h/0", epc_o, cause_o[31], model_epc);
    else
      pass_cnt++;
    check_redirect("prio");
    raise_eret();
    check_redirect("prio_eret");
  endtask

  task automatic test_hw_int_reset();
    mtc0(5'd13, 32'hFFFF_FFFF);
    total_cnt++;
    if (cause_o !== 32'h0000_0300)
      $display("FAIL cause_write: got %h expected 00000300", cause_o);
    else
      pass_cnt++;
    mtc0(5'd15, 32'h0);
    raddr_i = 5'd15;
    #1;
    total_cnt++;
    if (rdata_o !== 32'h004C_0102)
      $display("FAIL prid_readonly: got %h expected 004c0102", rdata_o);
    else
      pass_cnt++;
    hw_int_i = 5'b00001;
    mtc0(5'd12, 32'h0000_0401);
    total_cnt++;
    if (cause_o[10] !== 1'b1 || int_pending_o !== 1'b1)
      $display("FAIL hw_int: ip2 %b pending %b expected 1/1", cause_o[10], int_pending_o);
    else
      pass_cnt++;
    exc_valid_i = 1'b1; exc_code_i = 5'd0; exc_pc_i = 32'h8000_0400;
    tick();
    exc_valid_i = 1'b0;
    total_cnt++;
    if (redirect_valid_o !== 1'b1)
      $display("FAIL rst_pre_redirect: got %b expected 1", redirect_valid_o);
    else
      pass_cnt++;
    rst = 1'b1;
    hw_int_i = 5'b0;
    #1;
    total_cnt++;
    if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'h0)
      $display("FAIL rst_redirect: valid %b pc %h expected 0/0", redirect_valid_o, redirect_pc_o);
    else
      pass_cnt++;
    total_cnt++;
    if (status_o !== 32'h1000_0000 || cause_o !== 32'h0 || epc_o !== 32'h0 ||
        int_pending_o !== 1'b0 || timer_int_o !== 1'b0)
      $display("FAIL rst_regs: status %h cause %h epc %h pend %b timer %b expected 10000000/0/0/0/0",
               status_o, cause_o, epc_o, int_pending_o, timer_int_o);
    else
      pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
    hw_int_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; eret_i = 1'b0;
    exc_pc_i = '0; in_delayslot_i = 1'b0; badvaddr_i = '0;
    model_epc = '0;
    #2;
    test_reset();
    tick();
    rst = 1'b0;
    test_timer();
    test_exception();
    test_nested_eret();
    test_back_to_back_priority();
    test_hw_int_reset();
    total_cnt++;
    if (sb_q.size() != 0)
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
    else
      pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
